mult_scheduler: RTL and testbench

- Shares one external pipelined 24x24 signed multiplier (mult24x24, fixed latency) between NUM_REQ requesters.
- Round-robin arbitration issues at most one operand pair per cycle.
- A tag pipeline tracks the requester ID of every in-flight product. Completed products land in a result FIFO with a rsp_valid/rsp_ready handshake.
- Credit counting guarantees no product is ever dropped. Sits between puzzle-solver lanes and the shared DSP multiplier.

---
 rtl/mult_scheduler_if.sv | 35 +++
 rtl/mult_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_mult_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_scheduler_if.sv
// mult_scheduler_if: groups the bus signals of mult_scheduler.
//   req_valid/req_ready/req_a/req_b : per-requester operand handshake, requester i at [i*W +: W]
//   mul_a/mul_b/mul_p               : operands to and product from the shared pipelined multiplier
//   rsp_valid/rsp_ready/rsp_p/rsp_id: result stream in issue order
//   busy                            : work in flight or queued
// Modport slave is the scheduler's view; master is the surrounding logic.
interface mult_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned W       = 24
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*W-1:0] req_a;
    logic [NUM_REQ*W-1:0] req_b;
    logic [W-1:0]         mul_a;
    logic [W-1:0]         mul_b;
    logic [2*W-1:0]       mul_p;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [2*W-1:0]       rsp_p;
    logic [ID_W-1:0]      rsp_id;
    logic                 busy;

    modport slave (
        input  req_valid, req_a, req_b, mul_p, rsp_ready,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_p, rsp_id, busy
    );

    modport master (
        output req_valid, req_a, req_b, mul_p, rsp_ready,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_p, rsp_id, busy
    );
endinterface

// File: rtl/mult_scheduler.sv
// mult_scheduler: shares one external pipelined signed multiplier between NUM_REQ
// requesters. Round-robin issue of one operand pair per cycle, a tag pipeline that
// follows each product through the multiplier, and a first-word-fall-through result
// FIFO. An outstanding-credit counter (in-flight + queued) stops issue before the
// FIFO could ever overflow.
// Ports: clock, reset_n (async active-low), bus (mult_scheduler_if.slave).
// Optional: `define MULT_SCHED_PERF_EN adds perf_issued / perf_stall (32-bit, wrapping).
module mult_scheduler #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned W          = 24,
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    mult_scheduler_if.slave bus
`ifdef MULT_SCHED_PERF_EN
    ,
    output logic [31:0]     perf_issued,
    output logic [31:0]     perf_stall
`endif
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned P_W   = 2 * W;
    localparam int unsigned NSTG  = LATENCY + 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // Unpacked views of the packed operand buses
    logic [W-1:0] req_a_arr [NUM_REQ];
    logic [W-1:0] req_b_arr [NUM_REQ];
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_a_arr[i] = bus.req_a[i*W +: W];
        assign req_b_arr[i] = bus.req_b[i*W +: W];
    end

    logic             en_q, en_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [W-1:0]     mul_a_q, mul_a_d;
    logic [W-1:0]     mul_b_q, mul_b_d;
    logic [NSTG-1:0]  tag_vld_q, tag_vld_d;
    logic [ID_W-1:0]  tag_id_q [NSTG];
    logic [ID_W-1:0]  tag_id_d [NSTG];
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [P_W-1:0]   rsp_p_q, rsp_p_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [P_W-1:0]   fifo_p_q  [FIFO_DEPTH];
    logic [ID_W-1:0]  fifo_id_q [FIFO_DEPTH];

    logic               grant_vld_c;
    logic [ID_W-1:0]    grant_c;
    logic               can_issue_c;
    logic               issue_c;
    logic               push_c;
    logic               pop_c;
    logic [NUM_REQ-1:0] req_ready_c;
    int unsigned        idx_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Round-robin search starting one past the last granted requester
    always_comb begin
        grant_vld_c = 1'b0;
        grant_c     = '0;
        idx_c       = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx_c = 32'(rr_ptr_q) + k;
            if (idx_c >= NUM_REQ) idx_c = idx_c - NUM_REQ;
            if (!grant_vld_c && bus.req_valid[ID_W'(idx_c)]) begin
                grant_vld_c = 1'b1;
                grant_c     = ID_W'(idx_c);
            end
        end
        can_issue_c = (outst_q < CNT_W'(FIFO_DEPTH));
        // en_q keeps req_ready low while reset is asserted
        issue_c     = grant_vld_c && can_issue_c && en_q;
        req_ready_c = '0;
        if (issue_c) req_ready_c[grant_c] = 1'b1;
    end

    // Next state: issue, tag shift, FIFO pointers, credit and head register
    always_comb begin
        en_d      = 1'b1;
        rr_ptr_d  = issue_c ? grant_c : rr_ptr_q;
        mul_a_d   = issue_c ? req_a_arr[grant_c] : mul_a_q;
        mul_b_d   = issue_c ? req_b_arr[grant_c] : mul_b_q;
        tag_vld_d = {tag_vld_q[NSTG-2:0], issue_c};
        tag_id_d[0] = grant_c;
        for (int unsigned s = 1; s < NSTG; s++) tag_id_d[s] = tag_id_q[s-1];

        push_c   = tag_vld_q[LATENCY];
        pop_c    = (count_q != '0) && bus.rsp_ready;
        wr_ptr_d = push_c ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_c ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        count_d = count_q;
        if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
        else if (!push_c && pop_c) count_d = count_q - CNT_W'(1);

        outst_d = outst_q;
        if (issue_c && !pop_c)      outst_d = outst_q + CNT_W'(1);
        else if (!issue_c && pop_c) outst_d = outst_q - CNT_W'(1);

        // Head register: the incoming product becomes head when nothing older remains;
        // an empty FIFO keeps showing the last head.
        rsp_p_d  = rsp_p_q;
        rsp_id_d = rsp_id_q;
        if (count_d != '0) begin
            if ((count_q == '0) || ((count_q == CNT_W'(1)) && pop_c)) begin
                rsp_p_d  = bus.mul_p;
                rsp_id_d = tag_id_q[LATENCY];
            end else begin
                rsp_p_d  = fifo_p_q[rd_ptr_d];
                rsp_id_d = fifo_id_q[rd_ptr_d];
            end
        end
    end

    // Control and datapath state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            en_q      <= 1'b0;
            rr_ptr_q  <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            tag_vld_q <= '0;
            for (int unsigned s = 0; s < NSTG; s++) tag_id_q[s] <= '0;
            outst_q   <= '0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rsp_p_q   <= '0;
            rsp_id_q  <= '0;
        end else begin
            en_q      <= en_d;
            rr_ptr_q  <= rr_ptr_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            tag_vld_q <= tag_vld_d;
            for (int unsigned s = 0; s < NSTG; s++) tag_id_q[s] <= tag_id_d[s];
            outst_q   <= outst_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rsp_p_q   <= rsp_p_d;
            rsp_id_q  <= rsp_id_d;
        end
    end

    // Result storage; contents are only read behind valid pointers, so no reset
    always_ff @(posedge clock) begin
        if (push_c) begin
            fifo_p_q[wr_ptr_q]  <= bus.mul_p;
            fifo_id_q[wr_ptr_q] <= tag_id_q[LATENCY];
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(push_c && !pop_c && (count_q == CNT_W'(FIFO_DEPTH))));

    assign bus.req_ready = req_ready_c;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.rsp_valid = (count_q != '0);
    assign bus.rsp_p     = rsp_p_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = (|tag_vld_q) || (count_q != '0);

`ifdef MULT_SCHED_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Issue and credit-stall event counters
    always_comb begin
        perf_issued_d = perf_issued_q + (issue_c ? 32'd1 : 32'd0);
        perf_stall_d  = perf_stall_q + (((|bus.req_valid) && !can_issue_c) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`endif
endmodule

// File: tb/tb_mult_scheduler.sv
// tb_mult_scheduler: directed self-checking bench for mult_scheduler with a
// 4-stage signed multiplier model standing in for mult24x24.
module tb_mult_scheduler;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned W       = 24;
    localparam int unsigned LAT     = 4;
    localparam int unsigned DEPTH   = 8;

    typedef struct packed {
        logic [1:0]  id;
        logic [47:0] p;
    } rec_t;

    logic clock = 1'b0;
    logic reset_n;
    mult_scheduler_if #(.NUM_REQ(NUM_REQ), .W(W)) bus ();

    logic signed [W-1:0]   opa [NUM_REQ];
    logic signed [W-1:0]   opb [NUM_REQ];
    logic [NUM_REQ-1:0]    vld;
    logic signed [2*W-1:0] mpipe [LAT];

    rec_t exp_q[$];
    rec_t got_q[$];
    int   got_t[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc_n = 0;
    int   issued = 0;
    int   stalls = 0;

`ifdef MULT_SCHED_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_stall;
`endif

    always #5 clock = ~clock;

    mult_scheduler #(.NUM_REQ(NUM_REQ), .W(W), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef MULT_SCHED_PERF_EN
        ,
        .perf_issued (perf_issued),
        .perf_stall  (perf_stall)
`endif
    );

    always_comb begin
        bus.req_valid = vld;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_a[i*W +: W] = opa[i];
            bus.req_b[i*W +: W] = opb[i];
        end
    end

    // Multiplier model: product valid LAT edges after the operands change
    always @(posedge clock) begin
        mpipe[0] <= $signed(bus.mul_a) * $signed(bus.mul_b);
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign bus.mul_p = mpipe[LAT-1];

    // Record handshakes of the current cycle, then advance one clock
    task automatic cyc();
        rec_t r;
        logic signed [47:0] pr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (vld[i] && bus.req_ready[i]) begin
                pr = opa[i] * opb[i];
                r.id = 2'(i);
                r.p  = pr;
                exp_q.push_back(r);
                issued++;
            end
        end
        if ((|vld) && (bus.req_ready == '0)) stalls++;
        if (bus.rsp_valid && bus.rsp_ready) begin
            r.id = bus.rsp_id;
            r.p  = bus.rsp_p;
            got_q.push_back(r);
            got_t.push_back(cyc_n);
        end
        @(posedge clock);
        #1;
        cyc_n++;
    endtask

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
        got_t.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        vld = 4'hF;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            opa[i] = 24'sd1;
            opb[i] = 24'sd1;
        end
        repeat (2) @(posedge clock);
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.rsp_p !== 48'h0) begin failures++; $display("FAIL reset_rsp_p: got %h expected 0", bus.rsp_p); end
        checks++; if (bus.rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id: got %0d expected 0", bus.rsp_id); end
        checks++; if ({bus.mul_a, bus.mul_b} !== 48'h0) begin failures++; $display("FAIL reset_mul_ab: got %h %h expected 0 0", bus.mul_a, bus.mul_b); end
`ifdef MULT_SCHED_PERF_EN
        checks++; if ({perf_issued, perf_stall} !== 64'h0) begin failures++; $display("FAIL reset_perf: got %0d %0d expected 0 0", perf_issued, perf_stall); end
`endif
        vld = '0;
        reset_n = 1'b1;
        issued = 0;
        stalls = 0;
        repeat (3) cyc();
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL post_reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        clear_q();
    endtask

    task automatic test_single_op();
        opa[2] = -24'sd3;
        opb[2] = 24'sd7;
        vld = 4'b0100;
        bus.rsp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL single_grant: got %b expected 0100", bus.req_ready); end
        cyc();
        vld = '0;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL single_grant_once: got %b expected 0000", bus.req_ready); end
        for (int k = 1; k < 6; k++) begin
            checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid cycle %0d: got %b expected 0", k, bus.rsp_valid); end
            cyc();
        end
        checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL single_latency: rsp_valid got %b expected 1", bus.rsp_valid); end
        checks++; if (bus.rsp_p !== 48'hFFFF_FFFF_FFEB) begin failures++; $display("FAIL single_product: got %h expected ffffffffffeb (-21)", bus.rsp_p); end
        checks++; if (bus.rsp_id !== 2'd2) begin failures++; $display("FAIL single_id: got %0d expected 2", bus.rsp_id); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
        cyc();
        checks++; if ({bus.rsp_valid, bus.busy} !== 2'b00) begin failures++; $display("FAIL single_drained: valid,busy got %b expected 00", {bus.rsp_valid, bus.busy}); end
        checks++; if (bus.rsp_p !== 48'hFFFF_FFFF_FFEB) begin failures++; $display("FAIL single_hold_p: got %h expected ffffffffffeb", bus.rsp_p); end
        clear_q();
    endtask

    task automatic test_extremes();
        opa[0] = 24'h800000;
        opb[0] = 24'h800000;
        opa[1] = 24'h7FFFFF;
        opb[1] = 24'h800000;
        vld = 4'b0011;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL ext_grant0: got %b expected 0001", bus.req_ready); end
        cyc();
        vld = 4'b0010;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL ext_grant1: got %b expected 0010", bus.req_ready); end
        cyc();
        vld = '0;
        for (int n = 0; n < 20 && got_q.size() < 2; n++) cyc();
        checks++;
        if (got_q.size() != 2) begin
            failures++; $display("FAIL ext_count: got %0d results expected 2", got_q.size());
        end else begin
            // (-2^23)^2 = 2^46 ; (2^23-1)*(-2^23) = -(2^46-2^23)
            checks++; if (got_q[0] !== {2'd0, 48'h4000_0000_0000}) begin failures++; $display("FAIL ext_min_min: got id %0d p %h expected id 0 p 400000000000", got_q[0].id, got_q[0].p); end
            checks++; if (got_q[1] !== {2'd1, 48'hC000_0080_0000}) begin failures++; $display("FAIL ext_max_min: got id %0d p %h expected id 1 p c00000800000", got_q[1].id, got_q[1].p); end
        end
        clear_q();
    endtask

    task automatic test_fairness();
        logic [3:0]  expg;
        logic [47:0] prod [4];
        opa[3] = 24'sd2;
        opb[3] = 24'sd2;
        vld = 4'b1000;
        #1;
        checks++; if (bus.req_ready !== 4'b1000) begin failures++; $display("FAIL fair_prime: got %b expected 1000", bus.req_ready); end
        cyc();
        vld = '0;
        for (int n = 0; n < 20 && bus.busy; n++) cyc();
        clear_q();
        opa[0] = 24'sd5;  opb[0] = 24'sd3;
        opa[1] = -24'sd6; opb[1] = 24'sd3;
        opa[2] = 24'sd7;  opb[2] = -24'sd2;
        opa[3] = -24'sd8; opb[3] = 24'sd100;
        prod[0] = 48'd15;
        prod[1] = -48'sd18;
        prod[2] = -48'sd14;
        prod[3] = -48'sd800;
        vld = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            expg = 4'(1 << (k % 4));
            checks++; if (bus.req_ready !== expg) begin failures++; $display("FAIL fair_grant %0d: got %b expected %b", k, bus.req_ready, expg); end
            cyc();
        end
        vld = '0;
        for (int n = 0; n < 30 && bus.busy; n++) cyc();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL fair_drain_timeout: busy got %b expected 0", bus.busy); end
        checks++; if (got_q.size() != 8) begin failures++; $display("FAIL fair_count: got %0d expected 8", got_q.size()); end
        for (int k = 0; k < 8 && k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== {2'(k % 4), prod[k % 4]}) begin failures++; $display("FAIL fair_result %0d: got id %0d p %h expected id %0d p %h", k, got_q[k].id, got_q[k].p, k % 4, prod[k % 4]); end
            checks++; if (got_t[k] != got_t[0] + k) begin failures++; $display("FAIL fair_rate %0d: got cycle %0d expected %0d", k, got_t[k], got_t[0] + k); end
        end
        clear_q();
    endtask

    task automatic test_backpressure();
        int   k;
        logic acc;
        k = 0;
        bus.rsp_ready = 1'b0;
        opa[0] = 24'sd1;
        opb[0] = -24'sd1;
        vld = 4'b0001;
        for (int c = 0; c < 12; c++) begin
            #1;
            acc = bus.req_ready[0];
            checks++; if (acc !== (c < 8)) begin failures++; $display("FAIL bp_fill %0d: req_ready got %b expected %b", c, acc, (c < 8)); end
            cyc();
            if (acc) begin k++; opa[0] = 24'(k + 1); opb[0] = 24'(-(k + 1)); end
        end
        // Release, then toggle rsp_ready so pops and issues meet a full credit pool
        for (int c = 0; c < 24; c++) begin
            bus.rsp_ready = (c < 8 || c >= 16) ? 1'b1 : 1'(c % 2);
            #1;
            acc = bus.req_ready[0];
            if (c == 0) begin
                checks++; if (acc !== 1'b0) begin failures++; $display("FAIL bp_release_full: req_ready got %b expected 0", acc); end
            end
            if (c == 1) begin
                checks++; if (acc !== 1'b1) begin failures++; $display("FAIL bp_resume: req_ready got %b expected 1", acc); end
            end
            cyc();
            if (acc) begin k++; opa[0] = 24'(k + 1); opb[0] = 24'(-(k + 1)); end
        end
        vld = '0;
        bus.rsp_ready = 1'b1;
        for (int n = 0; n < 40 && bus.busy; n++) cyc();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL bp_drain_timeout: busy got %b expected 0", bus.busy); end
        checks++; if (got_q.size() != exp_q.size() || got_q.size() < 8) begin failures++; $display("FAIL bp_count: got %0d results expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== {2'd0, 48'(-((i + 1) * (i + 1)))}) begin failures++; $display("FAIL bp_first8 %0d: got %h expected %0d", i, got_q[i].p, -((i + 1) * (i + 1))); end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_order %0d: got id %0d p %h expected id %0d p %h", i, got_q[i].id, got_q[i].p, exp_q[i].id, exp_q[i].p); end
        end
        clear_q();
    endtask

    task automatic test_reset_midflight();
        int seen;
`ifdef MULT_SCHED_PERF_EN
        checks++; if (perf_issued !== 32'(issued)) begin failures++; $display("FAIL perf_issued: got %0d expected %0d", perf_issued, issued); end
        checks++; if (perf_stall !== 32'(stalls)) begin failures++; $display("FAIL perf_stall: got %0d expected %0d", perf_stall, stalls); end
`endif
        bus.rsp_ready = 1'b1;
        opa[1] = 24'sd9;
        opb[1] = 24'sd9;
        vld = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL mid_issue %0d: got %b expected 0010", c, bus.req_ready); end
            cyc();
        end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before: got %b expected 1", bus.busy); end
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if ({bus.rsp_valid, bus.busy} !== 2'b00) begin failures++; $display("FAIL mid_reset_outputs: valid,busy got %b expected 00", {bus.rsp_valid, bus.busy}); end
        checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL mid_reset_ready: got %b expected 0000", bus.req_ready); end
        vld = '0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        issued = 0;
        stalls = 0;
        clear_q();
`ifdef MULT_SCHED_PERF_EN
        checks++; if ({perf_issued, perf_stall} !== 64'h0) begin failures++; $display("FAIL mid_perf_zero: got %0d %0d expected 0 0", perf_issued, perf_stall); end
`endif
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.rsp_valid || bus.busy) seen++;
            cyc();
        end
        checks++; if (seen != 0 || got_q.size() != 0) begin failures++; $display("FAIL mid_stale: active cycles %0d results %0d expected 0 0", seen, got_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_op();
        test_extremes();
        test_fairness();
        test_backpressure();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
